baud_generator_cfg: RTL and testbench

Runtime-programmable successor to the fixed NCO baud generator. It produces the oversample, baud and mid-bit sample strobes shared by the UART RX and TX paths. The NCO increment and oversample ratio are loaded through a valid/ready config port and take effect only on a bit boundary. An RX resync input realigns the phase to a detected start-bit edge.

---
 rtl/baud_generator_cfg.sv | 125 ++++++++++++
 tb/tb_baud_generator_cfg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/baud_generator_cfg.sv
// Runtime-programmable NCO baud generator: oversample, baud and mid-bit strobes
// for the UART RX/TX paths, with bit-boundary config apply and RX phase resync.
module baud_generator_cfg #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEFAULT_BAUD = 115_200,
  parameter int OS_MAX       = 16,
  parameter int OS_DEFAULT   = 16,
  parameter int ACC_WIDTH    = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ACC_WIDTH-1:0]      cfg_inc,
  input  logic [$clog2(OS_MAX):0]   cfg_os,
  output logic                      cfg_err,
  input  logic                      rx_resync,
  output logic                      tick_oversample,
  output logic                      tick_baud,
  output logic                      tick_sample,
  output logic [$clog2(OS_MAX)-1:0] os_phase
);

  localparam int PW = $clog2(OS_MAX);
  localparam int OW = PW + 1;
  localparam longint unsigned DEFAULT_INC_L =
    (64'(DEFAULT_BAUD) * 64'(OS_DEFAULT) * (64'd1 << ACC_WIDTH) + 64'(CLK_HZ / 2)) / 64'(CLK_HZ);
  localparam logic [ACC_WIDTH-1:0] DEFAULT_INC = DEFAULT_INC_L[ACC_WIDTH-1:0];

  if ((OS_MAX % 2) != 0 || OS_MAX < 4) begin : g_bad_os_max
    $error("OS_MAX must be even and >= 4");
  end
  if ((OS_DEFAULT % 2) != 0 || OS_DEFAULT < 4 || OS_DEFAULT > OS_MAX) begin : g_bad_os_default
    $error("OS_DEFAULT must be even and within 4..OS_MAX");
  end
  if (ACC_WIDTH < 8) begin : g_bad_acc_width
    $error("ACC_WIDTH must be >= 8");
  end
  if (DEFAULT_INC_L == 64'd0 || DEFAULT_INC_L >= (64'd1 << ACC_WIDTH)) begin : g_bad_default_inc
    $error("DEFAULT_INC out of range for ACC_WIDTH");
  end

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] inc_q;
  logic [ACC_WIDTH-1:0] pend_inc;
  logic [OW-1:0]        os_q;
  logic [OW-1:0]        pend_os;
  logic [PW-1:0]        os_cnt;
  logic                 pending;

  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic                 at_last;
  logic                 at_mid;
  logic                 cfg_legal;
  logic                 take;
  logic                 apply;

  assign sum       = {1'b0, acc} + {1'b0, inc_q};
  assign carry     = sum[ACC_WIDTH];
  assign at_last   = ({1'b0, os_cnt} == (os_q - OW'(1)));
  assign at_mid    = ({1'b0, os_cnt} == ((os_q >> 1) - OW'(1)));
  assign cfg_legal = (cfg_inc != '0) && !cfg_os[0] &&
                     (cfg_os >= OW'(4)) && (cfg_os <= OW'(OS_MAX));
  assign take      = cfg_valid && cfg_ready;
  // A frozen or resyncing NCO has no bit boundary to wait for, so apply at once.
  assign apply     = pending && (rx_resync || !en || (carry && at_last));

  assign cfg_ready = !pending;
  assign os_phase  = os_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc             <= '0;
      os_cnt          <= '0;
      inc_q           <= DEFAULT_INC;
      os_q            <= OW'(OS_DEFAULT);
      pend_inc        <= '0;
      pend_os         <= '0;
      pending         <= 1'b0;
      cfg_err         <= 1'b0;
      tick_oversample <= 1'b0;
      tick_baud       <= 1'b0;
      tick_sample     <= 1'b0;
    end else begin
      tick_oversample <= 1'b0;
      tick_baud       <= 1'b0;
      tick_sample     <= 1'b0;
      cfg_err         <= take && !cfg_legal;

      if (take && cfg_legal) begin
        pend_inc <= cfg_inc;
        pend_os  <= cfg_os;
        pending  <= 1'b1;
      end

      // Half-step start phase puts the sample strobe mid start-bit.
      if (rx_resync) begin
        acc    <= {1'b1, {(ACC_WIDTH-1){1'b0}}};
        os_cnt <= '0;
      end else if (en) begin
        acc <= sum[ACC_WIDTH-1:0];
        if (carry) begin
          tick_oversample <= 1'b1;
          tick_sample     <= at_mid;
          if (at_last) begin
            os_cnt    <= '0;
            tick_baud <= 1'b1;
          end else begin
            os_cnt <= os_cnt + PW'(1);
          end
        end
      end

      if (apply) begin
        inc_q   <= pend_inc;
        os_q    <= pend_os;
        os_cnt  <= '0;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baud_generator_cfg.sv
// Directed bench for baud_generator_cfg: tick rates, config handshake/apply,
// illegal configs, resync alignment, enable freeze and mid-operation reset.
module tb_baud_generator_cfg;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst, en, cfg_valid, cfg_ready, cfg_err, rx_resync;
  logic          tick_oversample, tick_baud, tick_sample;
  logic [AW-1:0] cfg_inc;
  logic [4:0]    cfg_os;
  logic [3:0]    os_phase;

  int n_pass   = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  baud_generator_cfg dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_inc(cfg_inc), .cfg_os(cfg_os),
    .cfg_err(cfg_err), .rx_resync(rx_resync),
    .tick_oversample(tick_oversample), .tick_baud(tick_baud), .tick_sample(tick_sample),
    .os_phase(os_phase)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_baud(input int budget, output int n);
    n = 0;
    do begin cyc(); n++; end while (!tick_baud && n < budget);
    if (!tick_baud) chk("baud_timeout", 0, 1);
  endtask

  task automatic wait_flag(input int sel, input int budget);
    int n;
    n = 0;
    do begin cyc(); n++; end
    while (!((sel == 0) ? tick_oversample : tick_sample) && n < budget);
    if (!((sel == 0) ? tick_oversample : tick_sample)) chk("tick_timeout", 0, 1);
  endtask

  task automatic send_cfg(input logic [AW-1:0] inc, input logic [4:0] os);
    cfg_valid = 1'b1; cfg_inc = inc; cfg_os = os;
    cyc();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int nb, no, ns, bad, since, n, n2, idx, samp_idx, baud_idx, active;
    logic [3:0] pp, ph;
    logic r_prev;
    logic [AW-1:0] bi_inc [3];
    logic [4:0]    bi_os  [3];
    bi_inc = '{24'h800000, 24'h800000, 24'h000000};
    bi_os  = '{5'd5, 5'd2, 5'd4};

    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_inc = '0; cfg_os = '0; rx_resync = 1'b0;
    cyc(); cyc();
    chk("rst_ticks", {tick_oversample, tick_baud, tick_sample}, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_os_phase", os_phase, 0);
    rst = 1'b0; en = 1'b1;

    // default rate: 100 baud periods of ~434.03 cycles
    nb = 0; no = 0; ns = 0; bad = 0; since = -1;
    for (int i = 0; i < 43403; i++) begin
      pp = os_phase;
      cyc();
      if (tick_oversample) no++;
      if (tick_sample) begin
        ns++;
        if (pp != 4'd7) bad++;
        if (since >= 0) since++;
      end
      if (tick_baud) begin
        nb++;
        if (since >= 0 && since != 1) bad++;
        since = 0;
      end
    end
    chk("default_baud_count_in_99_101", (nb >= 99 && nb <= 101), 1);
    chk("default_os_count_in_1599_1601", (no >= 1599 && no <= 1601), 1);
    chk("default_sample_count_in_99_101", (ns >= 99 && ns <= 101), 1);
    chk("default_sample_placement_errors", bad, 0);

    // fast config issued mid-bit, applied at next boundary
    wait_flag(1, 1000);
    send_cfg(24'h800000, 5'd4);
    chk("cfg_ready_after_take", cfg_ready, 0);
    n = 0;
    do begin r_prev = cfg_ready; cyc(); n++; end while (!tick_baud && n < 600);
    chk("apply_seen", tick_baud, 1);
    chk("cfg_ready_on_apply_cycle", r_prev, 0);
    chk("cfg_ready_after_apply", cfg_ready, 1);
    chk("apply_os_phase", os_phase, 0);
    wait_baud(20, n);
    for (int k = 0; k < 4; k++) exp_q.push_back(8);
    for (int k = 0; k < 4; k++) begin
      wait_baud(20, n);
      chk("fast_baud_interval", n, exp_q.pop_front());
    end
    no = 0; ns = 0; nb = 0; bad = 0;
    for (int i = 0; i < 32; i++) begin
      pp = os_phase;
      cyc();
      if (tick_oversample) no++;
      if (tick_baud) nb++;
      if (tick_sample) begin ns++; if (pp != 4'd1) bad++; end
    end
    chk("fast_os_ticks_32cyc", no, 16);
    chk("fast_baud_ticks_32cyc", nb, 4);
    chk("fast_sample_ticks_32cyc", ns, 4);
    chk("fast_sample_phase_errors", bad, 0);

    // illegal configs
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(1);
      send_cfg(bi_inc[k], bi_os[k]);
      chk("illegal_cfg_err", cfg_err, exp_q.pop_front());
      chk("illegal_cfg_ready", cfg_ready, 1);
      cyc();
      chk("illegal_cfg_err_single", cfg_err, 0);
    end
    wait_baud(20, n);
    wait_baud(20, n);
    chk("illegal_spacing_unchanged", n, 8);

    // reset with a pending config and running accumulator
    send_cfg(24'h400000, 5'd8);
    rst = 1'b1;
    cyc();
    chk("midrst_ticks", {tick_oversample, tick_baud, tick_sample}, 0);
    chk("midrst_cfg_err", cfg_err, 0);
    chk("midrst_cfg_ready", cfg_ready, 1);
    chk("midrst_os_phase", os_phase, 0);
    rst = 1'b0;
    wait_baud(1000, n);
    wait_baud(1000, n);
    chk("midrst_default_interval_434_435", (n >= 434 && n <= 435), 1);

    // resync mid-bit
    wait_flag(1, 1000);
    repeat (50) cyc();
    rx_resync = 1'b1;
    cyc();
    rx_resync = 1'b0;
    chk("resync_os_phase", os_phase, 0);
    chk("resync_no_ticks", {tick_oversample, tick_baud, tick_sample}, 0);
    idx = 0; samp_idx = -1; baud_idx = -1; n = 0;
    while (baud_idx < 0 && n < 1000) begin
      cyc(); n++;
      if (tick_oversample) idx++;
      if (tick_sample && samp_idx < 0) samp_idx = idx;
      if (tick_baud) baud_idx = idx;
    end
    chk("resync_first_sample_os_idx", samp_idx, 8);
    chk("resync_first_baud_os_idx", baud_idx, 16);

    // freeze: phase resumes where it stopped
    wait_flag(0, 100);
    ph = os_phase; active = 0; bad = 0; n = 0;
    do begin
      en = (n < 5 || n >= 55);
      if (en) active++;
      cyc(); n++;
      if (!en && (os_phase != ph || tick_oversample || tick_baud || tick_sample)) bad++;
    end while (!tick_oversample && n < 200);
    en = 1'b1;
    chk("freeze_hold_errors", bad, 0);
    chk("freeze_active_edges_27_28", (active >= 27 && active <= 28), 1);

    // en=0 with pending config applies immediately
    en = 1'b0;
    send_cfg(24'h800000, 5'd4);
    chk("en0_cfg_ready_taken", cfg_ready, 0);
    cyc();
    chk("en0_cfg_ready_applied", cfg_ready, 1);
    chk("en0_os_phase", os_phase, 0);
    n2 = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (tick_oversample || tick_baud || tick_sample) n2++;
    end
    chk("en0_no_ticks", n2, 0);
    en = 1'b1;
    wait_baud(20, n);
    wait_baud(20, n);
    chk("en0_new_spacing", n, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
